// File: rtl/pwm_deadtime_multich.sv
// Multi-channel PWM with a shared period counter, per-channel complementary outputs
// with dead-time insertion, and double-buffered configuration applied at period wrap.
module pwm_deadtime_multich #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 13,
    parameter int unsigned DT_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         load,
    input  logic [CNT_W-1:0]             period,
    input  logic [CHANNELS*CNT_W-1:0]    duty,
    input  logic [DT_W-1:0]              dead_time,
    output logic [CHANNELS-1:0]          signal,
    output logic [CHANNELS-1:0]          signal_b,
    output logic [CHANNELS-1:0]          pwm_set,
    output logic [CHANNELS-1:0]          pwm_reset,
    output logic [CNT_W-1:0]             cnt,
    output logic                         period_start
);

    localparam int unsigned DUTY_W = CHANNELS * CNT_W;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_DEAD_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_DEAD_LO = 2'd3
    } state_e;

    logic [CNT_W-1:0]    pend_period_q, pend_period_d;
    logic [DUTY_W-1:0]   pend_duty_q,   pend_duty_d;
    logic [DT_W-1:0]     pend_dt_q,     pend_dt_d;
    logic [CNT_W-1:0]    act_period_q,  act_period_d;
    logic [DUTY_W-1:0]   act_duty_q,    act_duty_d;
    logic [DT_W-1:0]     act_dt_q,      act_dt_d;
    logic [CNT_W-1:0]    cnt_q,         cnt_d;
    logic                period_start_q, period_start_d;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [DT_W-1:0]     dead_q  [CHANNELS];
    logic [DT_W-1:0]     dead_d  [CHANNELS];

    logic [CHANNELS-1:0] signal_q,    signal_d;
    logic [CHANNELS-1:0] signal_b_q,  signal_b_d;
    logic [CHANNELS-1:0] pwm_set_q,   pwm_set_d;
    logic [CHANNELS-1:0] pwm_reset_q, pwm_reset_d;
    logic [CHANNELS-1:0] raw;

    logic running;
    logic wrap;
    logic running_next;
    logic starting;

    assign running      = (act_period_q != '0);
    assign wrap         = running && (cnt_q >= (act_period_q - CNT_W'(1)));
    assign running_next = (act_period_d != '0);
    assign starting     = en && !running && running_next;

    // Double-buffered config: pending always follows load, active only moves at a boundary
    always_comb begin
        pend_period_d = pend_period_q;
        pend_duty_d   = pend_duty_q;
        pend_dt_d     = pend_dt_q;
        act_period_d  = act_period_q;
        act_duty_d    = act_duty_q;
        act_dt_d      = act_dt_q;

        if (load) begin
            pend_period_d = period;
            pend_duty_d   = duty;
            pend_dt_d     = dead_time;
        end

        if (en && load && (!running || wrap)) begin
            act_period_d = period;
            act_duty_d   = duty;
            act_dt_d     = dead_time;
        end else if (en && wrap) begin
            act_period_d = pend_period_q;
            act_duty_d   = pend_duty_q;
            act_dt_d     = pend_dt_q;
        end
    end

    // Shared period counter and period-start strobe
    always_comb begin
        cnt_d          = cnt_q;
        period_start_d = 1'b0;
        if (en) begin
            if (!running || wrap) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            period_start_d = running_next && (cnt_d == '0);
        end
    end

    // Per-channel dead-time state machine, driven by the raw comparator phase
    always_comb begin
        raw = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            raw[k]     = (cnt_q < act_duty_q[k*CNT_W +: CNT_W]);
            state_d[k] = state_q[k];
            dead_d[k]  = dead_q[k];

            if (en) begin
                if (!running_next) begin
                    state_d[k] = ST_LOW;
                    dead_d[k]  = '0;
                end else if (starting) begin
                    // Start from a dead gap so neither phase can assert before raw is known
                    state_d[k] = ST_DEAD_LO;
                    dead_d[k]  = act_dt_d;
                end else begin
                    case (state_q[k])
                        ST_LOW: begin
                            if (raw[k]) begin
                                if (act_dt_q == '0) begin
                                    state_d[k] = ST_HIGH;
                                end else begin
                                    state_d[k] = ST_DEAD_HI;
                                    dead_d[k]  = act_dt_q;
                                end
                            end
                        end
                        ST_HIGH: begin
                            if (!raw[k]) begin
                                if (act_dt_q == '0) begin
                                    state_d[k] = ST_LOW;
                                end else begin
                                    state_d[k] = ST_DEAD_LO;
                                    dead_d[k]  = act_dt_q;
                                end
                            end
                        end
                        ST_DEAD_HI: begin
                            if (!raw[k]) begin
                                if (act_dt_q == '0) begin
                                    state_d[k] = ST_LOW;
                                    dead_d[k]  = '0;
                                end else begin
                                    state_d[k] = ST_DEAD_LO;
                                    dead_d[k]  = act_dt_q;
                                end
                            end else if (dead_q[k] <= DT_W'(1)) begin
                                state_d[k] = ST_HIGH;
                                dead_d[k]  = '0;
                            end else begin
                                dead_d[k]  = dead_q[k] - DT_W'(1);
                            end
                        end
                        ST_DEAD_LO: begin
                            if (raw[k]) begin
                                if (act_dt_q == '0) begin
                                    state_d[k] = ST_HIGH;
                                    dead_d[k]  = '0;
                                end else begin
                                    state_d[k] = ST_DEAD_HI;
                                    dead_d[k]  = act_dt_q;
                                end
                            end else if (dead_q[k] <= DT_W'(1)) begin
                                state_d[k] = ST_LOW;
                                dead_d[k]  = '0;
                            end else begin
                                dead_d[k]  = dead_q[k] - DT_W'(1);
                            end
                        end
                        default: begin
                            state_d[k] = ST_LOW;
                            dead_d[k]  = '0;
                        end
                    endcase
                end
            end
        end
    end

    // Outputs decoded from the next state, so they are mutually exclusive by construction
    always_comb begin
        signal_d    = '0;
        signal_b_d  = '0;
        pwm_set_d   = '0;
        pwm_reset_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            signal_d[k]   = (state_d[k] == ST_HIGH);
            signal_b_d[k] = (state_d[k] == ST_LOW) && running_next;
        end
        if (en) begin
            pwm_set_d   = signal_d & ~signal_q;
            pwm_reset_d = ~signal_d & signal_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_period_q  <= '0;
            pend_duty_q    <= '0;
            pend_dt_q      <= '0;
            act_period_q   <= '0;
            act_duty_q     <= '0;
            act_dt_q       <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            signal_q       <= '0;
            signal_b_q     <= '0;
            pwm_set_q      <= '0;
            pwm_reset_q    <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= ST_LOW;
                dead_q[k]  <= '0;
            end
        end else begin
            pend_period_q  <= pend_period_d;
            pend_duty_q    <= pend_duty_d;
            pend_dt_q      <= pend_dt_d;
            act_period_q   <= act_period_d;
            act_duty_q     <= act_duty_d;
            act_dt_q       <= act_dt_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
            signal_q       <= signal_d;
            signal_b_q     <= signal_b_d;
            pwm_set_q      <= pwm_set_d;
            pwm_reset_q    <= pwm_reset_d;
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= state_d[k];
                dead_q[k]  <= dead_d[k];
            end
        end
    end

    assign signal       = signal_q;
    assign signal_b     = signal_b_q;
    assign pwm_set      = pwm_set_q;
    assign pwm_reset    = pwm_reset_q;
    assign cnt          = cnt_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_deadtime_multich.sv
// Directed bench for pwm_deadtime_multich: a cycle-exact vector table for start-up,
// then hand-written sequences checking per-period widths and corner cases.
module tb_pwm_deadtime_multich;

    localparam int unsigned CH = 2;
    localparam int unsigned CW = 13;
    localparam int unsigned DW = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             load;
    logic [CW-1:0]    period;
    logic [CH*CW-1:0] duty;
    logic [DW-1:0]    dead_time;
    logic [CH-1:0]    sig;
    logic [CH-1:0]    sigb;
    logic [CH-1:0]    pset;
    logic [CH-1:0]    prst;
    logic [CW-1:0]    cnt;
    logic             ps;

    int n_vec = 0;
    int n_err = 0;

    pwm_deadtime_multich #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .DT_W     (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .load         (load),
        .period       (period),
        .duty         (duty),
        .dead_time    (dead_time),
        .signal       (sig),
        .signal_b     (sigb),
        .pwm_set      (pset),
        .pwm_reset    (prst),
        .cnt          (cnt),
        .period_start (ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic          ld;
        logic [CW-1:0] per;
        logic [CW-1:0] d0;
        logic [CW-1:0] d1;
        logic [DW-1:0] dt;
        logic [CW-1:0] e_cnt;
        logic [1:0]    e_sig;
        logic [1:0]    e_sigb;
        logic [1:0]    e_set;
        logic [1:0]    e_rst;
        logic          e_ps;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input int r, input int e, input int l, input int p,
                                input int d0, input int d1, input int dt, input int c,
                                input int s, input int sb, input int st, input int rs,
                                input int pst);
        vec_t v;
        v.rst    = r[0];
        v.en     = e[0];
        v.ld     = l[0];
        v.per    = CW'(p);
        v.d0     = CW'(d0);
        v.d1     = CW'(d1);
        v.dt     = DW'(dt);
        v.e_cnt  = CW'(c);
        v.e_sig  = 2'(s);
        v.e_sigb = 2'(sb);
        v.e_set  = 2'(st);
        v.e_rst  = 2'(rs);
        v.e_ps   = pst[0];
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        check("overlap", int'(sig & sigb), 0);
    endtask

    task automatic set_cfg(input int p, input int d0, input int d1, input int dt);
        period    = CW'(p);
        duty      = {CW'(d1), CW'(d0)};
        dead_time = DW'(dt);
    endtask

    task automatic do_load(input int p, input int d0, input int d1, input int dt);
        set_cfg(p, d0, d1, dt);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic align_to(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (int'(cnt) != target && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(cnt), target);
    endtask

    task automatic measure(input int n, output int s0, output int sb0, output int s1,
                           output int sb1, output int set0, output int rst0,
                           output int set1, output int pst, output int gap0);
        s0 = 0; sb0 = 0; s1 = 0; sb1 = 0; set0 = 0; rst0 = 0; set1 = 0; pst = 0; gap0 = 0;
        for (int i = 0; i < n; i++) begin
            s0   += int'(sig[0]);
            sb0  += int'(sigb[0]);
            s1   += int'(sig[1]);
            sb1  += int'(sigb[1]);
            set0 += int'(pset[0]);
            rst0 += int'(prst[0]);
            set1 += int'(pset[1]);
            pst  += int'(ps);
            gap0 += int'(!sig[0] && !sigb[0]);
            tick();
        end
    endtask

    initial begin
        int s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0;

        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        set_cfg(0, 0, 0, 0);

        // rst en ld  P  D0 D1 DT | cnt sig sigb set rst ps
        vecs[0]  = mk(1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 10, 3, 7, 2,  0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(0, 1, 0, 10, 3, 7, 2,  1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 10, 3, 7, 2,  2, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 10, 3, 7, 2,  3, 3, 0, 3, 0, 0);
        vecs[5]  = mk(0, 1, 0, 10, 3, 7, 2,  4, 2, 0, 0, 1, 0);
        vecs[6]  = mk(0, 1, 0, 10, 3, 7, 2,  5, 2, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 10, 3, 7, 2,  6, 2, 1, 0, 0, 0);
        vecs[8]  = mk(0, 1, 0, 10, 3, 7, 2,  7, 2, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 10, 3, 7, 2,  8, 0, 1, 0, 2, 0);
        vecs[10] = mk(0, 1, 0, 10, 3, 7, 2,  9, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 10, 3, 7, 2,  0, 0, 3, 0, 0, 1);
        vecs[12] = mk(0, 1, 0, 10, 3, 7, 2,  1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            reset = vecs[i].rst;
            en    = vecs[i].en;
            load  = vecs[i].ld;
            set_cfg(int'(vecs[i].per), int'(vecs[i].d0), int'(vecs[i].d1), int'(vecs[i].dt));
            tick();
            check($sformatf("vec%0d", i),
                  int'({cnt, sig, sigb, pset, prst, ps}),
                  int'({vecs[i].e_cnt, vecs[i].e_sig, vecs[i].e_sigb,
                        vecs[i].e_set, vecs[i].e_rst, vecs[i].e_ps}));
        end
        load = 1'b0;

        // Steady period P=10 D0=3 D1=7 DT=2
        align_to(0, 20, "align_basic");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("basic_s0", s0, 1);
        check("basic_sb0", sb0, 5);
        check("basic_s1", s1, 5);
        check("basic_sb1", sb1, 1);
        check("basic_set0", set0, 1);
        check("basic_rst0", rst0, 1);
        check("basic_set1", set1, 1);
        check("basic_ps", pst, 1);
        check("basic_gap0", gap0, 4);

        // Load at cnt=4: current period keeps D0=3
        align_to(4, 20, "align_g4");
        do_load(10, 6, 7, 2);
        measure(5, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("glitch_cur_s0", s0, 0);
        check("glitch_cur_sb0", sb0, 4);
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("glitch_new_s0", s0, 4);
        check("glitch_new_sb0", sb0, 2);
        check("glitch_new_set0", set0, 1);

        // Load in the wrap cycle: active from the following cnt=0
        align_to(9, 20, "align_g9");
        do_load(10, 4, 7, 2);
        check("wrapload_cnt", int'(cnt), 0);
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("wrapload_s0", s0, 2);
        check("wrapload_sb0", sb0, 4);

        // D0=0
        do_load(10, 0, 7, 2);
        align_to(0, 20, "align_d0");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("d0zero_s0", s0, 0);
        check("d0zero_sb0", sb0, 10);
        check("d0zero_set0", set0, 0);

        // D0=P
        do_load(10, 10, 7, 2);
        align_to(0, 20, "align_dp");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("dfull_s0", s0, 10);
        check("dfull_sb0", sb0, 0);
        check("dfull_edges0", set0 + rst0, 0);

        // DT=0 square wave
        do_load(10, 5, 7, 0);
        align_to(0, 20, "align_dt0");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("dt0_s0", s0, 5);
        check("dt0_sb0", sb0, 5);
        check("dt0_gap0", gap0, 0);
        check("dt0_s1", s1, 7);
        check("dt0_sb1", sb1, 3);

        // Dead time swallows the pulse
        do_load(10, 2, 7, 3);
        align_to(0, 20, "align_sw");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("swallow_s0", s0, 0);
        check("swallow_set0", set0, 0);
        check("swallow_sb0", sb0, 5);
        check("swallow_s1", s1, 4);
        check("swallow_sb1", sb1, 0);

        // en pause in DEAD_HI
        do_load(10, 3, 7, 2);
        align_to(0, 20, "align_pause");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        tick();
        check("pause_pre_cnt", int'(cnt), 1);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("pause_cnt", int'(cnt), 1);
            check("pause_out", int'({sig, sigb, pset, prst, ps}), 0);
        end
        en = 1'b1;
        tick();
        check("resume_cnt2", int'(cnt), 2);
        check("resume_sig2", int'(sig), 0);
        tick();
        check("resume_cnt3", int'(cnt), 3);
        check("resume_sig3", int'({sig, pset}), int'({2'b11, 2'b11}));
        align_to(0, 20, "align_resume");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("resume_s0", s0, 1);
        check("resume_sb0", sb0, 5);

        // Reset mid-period, then restart from stopped
        align_to(3, 20, "align_rst");
        check("prereset_sig", int'(sig), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_out", int'({cnt, sig, sigb, pset, prst, ps}), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stopped_out", int'({cnt, sig, sigb, pset, prst, ps}), 0);
        end
        do_load(10, 0, 10, 2);
        check("start_cnt_ps", int'({cnt, ps}), 1);
        check("start_out", int'({sig, sigb}), 0);
        tick();
        check("start_gap", int'({sig, sigb}), 0);
        tick();
        check("start_sb0", int'({sig, sigb}), int'({2'b00, 2'b01}));
        tick();
        check("start_s1", int'({sig, sigb, pset}), int'({2'b10, 2'b01, 2'b10}));
        align_to(0, 20, "align_start");
        measure(10, s0, sb0, s1, sb1, set0, rst0, set1, pst, gap0);
        check("start_s0", s0, 0);
        check("start_sb0w", sb0, 10);
        check("start_s1w", s1, 10);
        check("start_sb1w", sb1, 0);
        check("start_psw", pst, 1);

        // Load period=0: stops at the next wrap
        align_to(5, 20, "align_stop");
        do_load(0, 0, 10, 2);
        align_to(9, 20, "align_stop9");
        check("prestop_out", int'({sig, sigb}), int'({2'b10, 2'b01}));
        tick();
        check("stop_cnt", int'(cnt), 0);
        check("stop_out", int'({sig, sigb, pset, prst, ps}),
              int'({2'b00, 2'b00, 2'b00, 2'b10, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stopheld_out", int'({cnt, sig, sigb, pset, prst, ps}), 0);
        end

        // Largest period wraps cleanly
        do_load(8191, 1, 0, 0);
        check("max_start", int'({cnt, ps}), 1);
        align_to(8190, 9000, "align_max");
        check("max_out", int'({sig, sigb}), int'({2'b00, 2'b11}));
        tick();
        check("max_wrap", int'({cnt, ps}), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_multich.md
Name: pwm_deadtime_multich

Overview:
N-channel PWM generator for driving photonic switch pairs. All channels share one period counter. Each channel has its own duty word and produces a complementary signal/signal_b pair with programmable dead time, plus one-cycle set/reset strobes for the latch stage. Configuration is double-buffered: words written with load take effect only at a period boundary, so a running waveform never glitches.

Parameters:
CHANNELS, 4, number of independent PWM channels
CNT_W, 13, width of the period counter and of the period/duty words
DT_W, 4, width of the dead-time word

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
en  input  1  clock enable; when low, all state holds
load  input  1  strobe: capture period/duty/dead_time into the pending registers
period  input  CNT_W  period in clk cycles; 0 = stopped
duty  input  CHANNELS*CNT_W  per-channel high count; channel k occupies bits [k*CNT_W +: CNT_W]
dead_time  input  DT_W  dead-time cycles, applied to every channel
signal  output  CHANNELS  main phase per channel
signal_b  output  CHANNELS  complementary phase per channel
pwm_set  output  CHANNELS  1-cycle pulse in the cycle signal[k] rises
pwm_reset  output  CHANNELS  1-cycle pulse in the cycle signal[k] falls
cnt  output  CNT_W  current period count
period_start  output  1  1-cycle pulse when cnt==0 while running and en=1

Behaviour:
- Reset (clk edge with reset=1): cnt, signal, signal_b, pwm_set, pwm_reset, period_start, all pending and active registers, and all dead counters go to 0. reset takes priority over en and load.
- en=0: nothing changes. This covers cnt, outputs, dead counters, and active/pending registers, except that load still writes the pending registers. pwm_set, pwm_reset and period_start are forced to 0.
- Stopped state (active period P==0, which is the state after reset):
  - cnt is held at 0.
  - signal and signal_b are both 0.
  - A load while stopped makes the new values active on the next edge. cnt is 0 on that cycle and counting starts from it.
- Running (P>0, en=1):
  - cnt counts 0..P-1, then wraps to 0.
  - Wrap cycle = the cycle with cnt==P-1. At the edge that ends it, the pending registers are copied to the active registers.
  - If load and the wrap cycle coincide, the input values are used directly, so the new config is active from cnt=0.
  - Loading period=0 stops the block at the next wrap. Both outputs go low immediately after that edge.
- Raw phase per channel: raw[k] = (cnt < D[k]), using the active duty.
  - D=0: raw is always low.
  - D>=P: raw is always high.
- Dead-time state machine per channel, states LOW, DEAD_HI, HIGH, DEAD_LO. Outputs are registered; all delays below are measured from raw.
  - raw rises: signal_b drops at the next edge. The state enters DEAD_HI and the dead counter loads DT.
  - DEAD_HI: both outputs low. After DT edges in DEAD_HI, signal rises and the state is HIGH.
  - The falling edge is symmetric through DEAD_LO into LOW, with signal_b rising.
  - DT=0: the DEAD states are skipped. signal = raw and signal_b = ~raw, each delayed by 1 cycle.
  - raw reverses during DEAD_x: the state switches to the opposite DEAD state and the counter reloads DT. Both outputs stay low.
  - Consequences: signal high width = D-DT; signal_b high width = P-D-DT; there are two dead gaps of DT per period.
  - If D<=DT, signal never rises. If P-D<=DT, signal_b never rises.
- signal and signal_b are never 1 in the same cycle. This invariant holds under all inputs.
- pwm_set[k] and pwm_reset[k] are registered and coincide with the output edge of signal[k]. They are mutually exclusive.
- Dead time is taken from the active registers, so it changes only at a wrap.
- Width rules:
  - All comparisons are unsigned CNT_W.
  - The dead counter is DT_W wide and counts down to 0; there is no arithmetic overflow.
  - period=2^CNT_W-1 is legal.

Test Plan:
- Basic run: CHANNELS=2, reset, then load P=10, D0=3, D1=7, DT=2 -> each period: ch0 signal high 1 cycle, signal_b high 5 cycles; ch1 signal high 5, signal_b high 1; 2-cycle both-low gaps; period_start every 10 cycles; one pwm_set and one pwm_reset per channel per period.
- Glitch-free update: while running P=10, D0=3, pulse load with D0=6 at cnt=4 -> the current period is unchanged; D0=6 (signal high 4) starts at the next cnt=0. Repeat with load at cnt=9 -> the new value is active from that cnt=0.
- Extremes: D0=0 -> signal0 never high, signal_b0 constantly high after the initial dead gap. D0=10 (=P) -> signal0 constantly high. DT=0, D0=5 -> a 5/5 complementary square wave with no gap.
- Dead time swallows the pulse: P=10, D0=2, DT=3 -> signal0 stays 0 and no pwm_set[0] occurs; signal_b0 is high 5 cycles per period. signal&signal_b==0 is checked every cycle.
- en pause: running, drop en for 7 cycles mid-DEAD_HI -> cnt and outputs freeze and strobes are 0; on resume the remaining dead cycles complete and the waveform continues seamlessly.
- Reset/stop: assert reset for 1 cycle mid-period -> next cycle all outputs are 0 and the block is stopped until the next load. Separately, load period=0 -> both outputs go low after the next wrap and cnt holds at 0.
